// File: rtl/lab2_debug_cmd_ctrl.sv
// lab2_debug_cmd_ctrl
// Takes update-DR / update-IR strobes from a virtual JTAG domain and brings them
// into the system clock domain. Each update-DR captures {ir_in, sr} into a small
// first-word-fall-through command queue that a consumer drains with cmd_ready.
// Update-IR strobes are reported as a one-cycle uir_pulse and do not touch the queue.
module lab2_debug_cmd_ctrl #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     cmd_ready,
  input  logic                     ovf_clr,
  output logic                     cmd_valid,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          jdo,
  output logic                     take_action,
  output logic                     take_no_action,
  output logic                     uir_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = IR_W + SR_W;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_hist;
  logic                   uir_hist;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   udr_pulse;

  logic [CMD_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_next;
  logic [CNT_W-1:0]       count_next;
  logic [CMD_W-1:0]       new_cmd;
  logic [CMD_W-1:0]       head_next;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   push_ok;
  logic                   drop;
  logic                   bypass;

  // Edges are only trusted once the synchronisers have flushed whatever level
  // was present at reset release.
  assign armed = (arm_cnt == ARM_DONE);

  // Synchronise both strobes, remember the last synchronised level, and emit a
  // registered single-cycle pulse on each rising edge once armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      udr_hist  <= 1'b0;
      uir_hist  <= 1'b0;
      arm_cnt   <= '0;
      udr_pulse <= 1'b0;
      uir_pulse <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist  <= udr_sync[SYNC_STAGES-1];
      uir_hist  <= uir_sync[SYNC_STAGES-1];
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
      udr_pulse <= armed & udr_sync[SYNC_STAGES-1] & ~udr_hist;
      uir_pulse <= armed & uir_sync[SYNC_STAGES-1] & ~uir_hist;
    end
  end

  assign push        = udr_pulse;
  assign pop         = cmd_valid & cmd_ready;
  assign full        = (fifo_count == CNT_W'(DEPTH));
  assign push_ok     = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign new_cmd     = {ir_in, sr};
  assign rd_ptr_next = rd_ptr + PTR_W'(pop);

  // Work out the next occupancy and which command will sit at the head after
  // this edge; when nothing older remains, the incoming command goes straight out.
  always_comb begin
    count_next = fifo_count;
    case ({push_ok, pop})
      2'b10:   count_next = fifo_count + CNT_W'(1);
      2'b01:   count_next = fifo_count - CNT_W'(1);
      default: count_next = fifo_count;
    endcase
    bypass    = pop ? (fifo_count == CNT_W'(1)) : (fifo_count == '0);
    head_next = bypass ? new_cmd : mem[rd_ptr_next];
  end

  // Command storage; an accepted push always lands in a slot that is free or
  // being vacated in the same cycle.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_cmd;
    end
  end

  // Pointers, occupancy, sticky overflow and the registered head of the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_ir     <= '0;
      jdo        <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      fifo_count <= count_next;
      cmd_valid  <= (count_next != '0);
      if (count_next != '0) begin
        {cmd_ir, jdo} <= head_next;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign take_action    = cmd_valid &  jdo[SR_W-1];
  assign take_no_action = cmd_valid & ~jdo[SR_W-1];

endmodule
